// File: rtl/aes_pkg.sv
// Shared AES constants and the input-loader state encoding.
package aes_pkg;

  localparam int unsigned AES_BLOCK_W = 128;
  localparam int unsigned AES_WORD_W  = 32;

  typedef enum logic [1:0] {
    LOAD_KEY,
    LOAD_DATA,
    START,
    WAIT_DONE
  } loader_state_t;

endpackage

// File: rtl/aes_word_packer.sv
// Shift-left assembler: each enabled cycle pushes din into the LSBs so the
// first word ends up in the MSBs once the operand is complete.
module aes_word_packer #(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned BLOCK_W = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               shift_en,
  input  logic [WORD_W-1:0]  din,
  output logic [BLOCK_W-1:0] dout
);

  logic [BLOCK_W-1:0] r_shift;

  // Operand shift register; holds its value whenever shift_en is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= '0;
    end else if (shift_en) begin
      r_shift <= (r_shift << WORD_W) | BLOCK_W'(din);
    end
  end

  assign dout = r_shift;

endmodule

// File: rtl/aes_block_loader.sv
// Input-side front end of the AES core: gathers key then plaintext words from
// a valid/ready stream, pulses start, and holds the operands until done.
module aes_block_loader
  import aes_pkg::*;
#(
  parameter int unsigned WORD_W  = AES_WORD_W,
  parameter int unsigned BLOCK_W = AES_BLOCK_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [WORD_W-1:0]  in_data,
  output logic               in_ready,
  input  logic               done,
  output logic               start,
  output logic [BLOCK_W-1:0] key,
  output logic [BLOCK_W-1:0] plain,
  output logic               busy
);

  localparam int unsigned N_WORDS = BLOCK_W / WORD_W;
  localparam int unsigned CNT_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  loader_state_t      r_state;
  logic [CNT_W-1:0]   r_beat;
  logic               r_in_ready;
  logic               r_start;
  logic               r_busy;

  logic               w_accept;
  logic               w_last_beat;
  logic               w_key_shift;
  logic               w_plain_shift;

  assign w_accept      = in_valid && r_in_ready;
  assign w_last_beat   = (r_beat == CNT_W'(N_WORDS - 1));
  assign w_key_shift   = w_accept && (r_state == LOAD_KEY);
  assign w_plain_shift = w_accept && (r_state == LOAD_DATA);

  aes_word_packer #(
    .WORD_W  (WORD_W),
    .BLOCK_W (BLOCK_W)
  ) u_key_packer (
    .clk      (clk),
    .reset    (reset),
    .shift_en (w_key_shift),
    .din      (in_data),
    .dout     (key)
  );

  aes_word_packer #(
    .WORD_W  (WORD_W),
    .BLOCK_W (BLOCK_W)
  ) u_plain_packer (
    .clk      (clk),
    .reset    (reset),
    .shift_en (w_plain_shift),
    .din      (in_data),
    .dout     (plain)
  );

  // Loader FSM with beat counter; in_ready/start/busy are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= LOAD_KEY;
      r_beat     <= '0;
      r_in_ready <= 1'b0;
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        LOAD_KEY: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            if (w_last_beat) begin
              r_beat  <= '0;
              r_state <= LOAD_DATA;
            end else begin
              r_beat <= r_beat + CNT_W'(1);
            end
          end
        end
        LOAD_DATA: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            if (w_last_beat) begin
              // Drop ready on the same edge so no word slips in behind the block.
              r_beat     <= '0;
              r_state    <= START;
              r_in_ready <= 1'b0;
              r_start    <= 1'b1;
              r_busy     <= 1'b1;
            end else begin
              r_beat <= r_beat + CNT_W'(1);
            end
          end
        end
        START: begin
          // done is deliberately not looked at until WAIT_DONE.
          r_state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (done) begin
            r_busy     <= 1'b0;
            r_in_ready <= 1'b1;
            r_state    <= LOAD_KEY;
          end
        end
        default: begin
          r_state    <= LOAD_KEY;
          r_beat     <= '0;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = r_in_ready;
  assign start    = r_start;
  assign busy     = r_busy;

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed bench for aes_block_loader with a start-triggered operand scoreboard.
module tb_aes_block_loader;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BLOCK_W = 128;
  localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic [WORD_W-1:0]  in_data;
  logic               in_ready;
  logic               done;
  logic               start;
  logic [BLOCK_W-1:0] key;
  logic [BLOCK_W-1:0] plain;
  logic               busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cnt = 0;
  logic prev_start = 1'b0;
  logic [255:0] exp_q[$];
  int start_cyc_q[$];
  logic [255:0] sb_exp;

  aes_block_loader #(.WORD_W(WORD_W), .BLOCK_W(BLOCK_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .done     (done),
    .start    (start),
    .key      (key),
    .plain    (plain),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    check(tag, 256'(obs), 256'(exp));
  endtask

  // Scoreboard: every start must match the oldest pending operand pair.
  always @(negedge clk) begin
    if (start === 1'b1) begin
      start_cnt++;
      start_cyc_q.push_back(cyc);
      check("sb_pending", 256'(exp_q.size() != 0), 256'(1'b1));
      if (exp_q.size() != 0) begin
        sb_exp = exp_q.pop_front();
        check("sb_operands", {key, plain}, sb_exp);
      end
      chk_bit("start_single_cycle", prev_start, 1'b0);
    end
    prev_start = start;
  end

  function automatic logic [31:0] word_of(input logic [127:0] k, input logic [127:0] p, input int i);
    logic [255:0] kp;
    kp = {k, p};
    return kp[255 - 32*i -: 32];
  endfunction

  // Called at a negedge; returns at the negedge after the beat transferred.
  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk_bit("send_ready_timeout", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full block: queues expected operands, optional idle gap, optional done during one beat.
  task automatic load_block(input logic [127:0] k, input logic [127:0] p, input int gap, input int done_beat);
    exp_q.push_back({k, p});
    for (int i = 0; i < 8; i++) begin
      if (i == done_beat) done = 1'b1;
      send_word(word_of(k, p, i));
      done = 1'b0;
      if (gap > 0 && i < 7) begin
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  // From the START cycle: move into WAIT_DONE, then give one done pulse.
  task automatic finish_block();
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk_bit("finish_busy_low", busy, 1'b0);
    chk_bit("finish_ready_high", in_ready, 1'b1);
  endtask

  initial begin
    logic [127:0] k5;
    logic [127:0] p5;
    logic [127:0] k6;
    logic [127:0] p6;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    done = 1'b0;
    repeat (3) @(negedge clk);
    chk_bit("rst_in_ready", in_ready, 1'b0);
    chk_bit("rst_start", start, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    check("rst_key_plain", {key, plain}, 256'(0));
    reset = 1'b0;
    @(negedge clk);
    chk_bit("ready_after_reset", in_ready, 1'b1);

    // FIPS-197 operands, gap-free
    load_block(FK, FP, 0, -1);
    chk_bit("fips_start", start, 1'b1);
    chk_bit("fips_busy_at_start", busy, 1'b1);
    chk_bit("fips_ready_at_start", in_ready, 1'b0);
    @(negedge clk);
    chk_bit("fips_start_drop", start, 1'b0);
    chk_bit("fips_busy_wait", busy, 1'b1);
    repeat (3) @(negedge clk);
    check("fips_frozen", {key, plain}, {FK, FP});
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk_bit("fips_done_busy", busy, 1'b0);
    chk_bit("fips_done_ready", in_ready, 1'b1);
    check("fips_kept_after_done", {key, plain}, {FK, FP});
    check("fips_start_cnt", 256'(start_cnt), 256'(1));

    // Reset in the middle of LOAD_DATA
    for (int i = 0; i < 6; i++) send_word(word_of(~FK, ~FP, i));
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_key_plain", {key, plain}, 256'(0));
    chk_bit("midrst_ready", in_ready, 1'b0);
    chk_bit("midrst_busy", busy, 1'b0);
    chk_bit("midrst_start", start, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk_bit("midrst_ready_back", in_ready, 1'b1);
    load_block(FK, FP, 0, -1);
    finish_block();

    // Gappy stream: valid pattern 1,0,0,1,...
    load_block(FK, FP, 2, -1);
    finish_block();
    check("gappy_start_cnt", 256'(start_cnt), 256'(3));

    // Spurious done in LOAD_KEY beat 2 and in the START cycle
    load_block(128'h0f0e0d0c0b0a09080706050403020100, 128'hffeeddccbbaa99887766554433221100, 0, 2);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk_bit("spur_busy_after_start_done", busy, 1'b1);
    chk_bit("spur_ready_after_start_done", in_ready, 1'b0);
    repeat (3) @(negedge clk);
    chk_bit("spur_busy_held", busy, 1'b1);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk_bit("spur_real_done", busy, 1'b0);

    // Hold: valid words offered during WAIT_DONE, done held three cycles
    k5 = 128'h11111111222222223333333344444444;
    p5 = 128'h55555555666666667777777788888888;
    k6 = 128'ha0a1a2a3b0b1b2b3c0c1c2c3d0d1d2d3;
    p6 = 128'he0e1e2e3f0f1f2f39091929380818283;
    load_block(k5, p5, 0, -1);
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 32'hdeadbeef;
    repeat (4) @(negedge clk);
    chk_bit("hold_ready_low", in_ready, 1'b0);
    check("hold_frozen", {key, plain}, {k5, p5});
    exp_q.push_back({k6, p6});
    done = 1'b1;
    in_data = word_of(k6, p6, 0);
    @(negedge clk);
    chk_bit("hold_ready_after_done", in_ready, 1'b1);
    chk_bit("hold_busy_after_done", busy, 1'b0);
    check("hold_plain_kept", 256'(plain), 256'(p5));
    for (int i = 0; i < 8; i++) begin
      send_word(word_of(k6, p6, i));
      if (i == 1) done = 1'b0;
    end
    in_valid = 1'b0;
    finish_block();

    // Back-to-back with done sampled 12 edges after each start edge
    load_block(128'h0123456789abcdef0123456789abcdef, 128'hfedcba9876543210fedcba9876543210, 0, -1);
    repeat (11) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    load_block(128'h13579bdf02468ace13579bdf02468ace, 128'h2468ace013579bdf2468ace013579bdf, 0, -1);
    finish_block();
    repeat (2) @(negedge clk);
    check("total_start_cnt", 256'(start_cnt), 256'(8));
    check("sb_drained", 256'(exp_q.size()), 256'(0));
    if (start_cyc_q.size() >= 2)
      check("b2b_period", 256'(start_cyc_q[start_cyc_q.size()-1] - start_cyc_q[start_cyc_q.size()-2]), 256'(20));
    else
      check("b2b_start_seen", 256'(start_cyc_q.size()), 256'(2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
